// File: rtl/ram_wb_arb.sv
// Two-port round-robin write arbiter driving the ram_wb write port.
// Port A is the CPU write-back stage, port B the debug/program loader.
module ram_wb_arb #(
   parameter int                ADDR_W  = 8,
   parameter int                DATA_W  = 16,
   parameter logic [ADDR_W-1:0] IO_ADDR = 8'h40,
   parameter int                CNT_W   = 16
) (
   input  logic              CLK_WB,
   input  logic              RESET_N,
   input  logic              HOLD,
   input  logic              REQ_A,
   input  logic [ADDR_W-1:0] ADDR_A,
   input  logic [DATA_W-1:0] DATA_A,
   output logic              ACK_A,
   input  logic              REQ_B,
   input  logic [ADDR_W-1:0] ADDR_B,
   input  logic [DATA_W-1:0] DATA_B,
   output logic              ACK_B,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_IN,
   output logic              RAM_WEN,
   output logic              BUSY,
   output logic              IO_WR,
   output logic [CNT_W-1:0]  WR_CNT
);

   typedef enum logic {IDLE, WRITE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state;
   logic              last_b;
   logic              grant_b;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      grant_b  = REQ_B && !(REQ_A && last_b);
      win_addr = grant_b ? ADDR_B : ADDR_A;
      win_data = grant_b ? DATA_B : DATA_A;
   end

   always_ff @(posedge CLK_WB or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         last_b   <= 1'b1;
         RAM_ADDR <= '0;
         RAM_IN   <= '0;
         RAM_WEN  <= 1'b0;
         ACK_A    <= 1'b0;
         ACK_B    <= 1'b0;
         BUSY     <= 1'b0;
         IO_WR    <= 1'b0;
         WR_CNT   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!HOLD && (REQ_A || REQ_B)) begin
                  RAM_ADDR <= win_addr;
                  RAM_IN   <= win_data;
                  RAM_WEN  <= 1'b1;
                  ACK_A    <= !grant_b;
                  ACK_B    <= grant_b;
                  BUSY     <= 1'b1;
                  IO_WR    <= (win_addr == IO_ADDR);
                  last_b   <= grant_b;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               // The write always completes; HOLD and requests are ignored here.
               RAM_WEN <= 1'b0;
               ACK_A   <= 1'b0;
               ACK_B   <= 1'b0;
               BUSY    <= 1'b0;
               IO_WR   <= 1'b0;
               WR_CNT  <= WR_CNT + CNT_ONE;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_wb_arb.sv
// Self-checking bench for ram_wb_arb: directed scenarios plus a randomized
// two-requester run, all checked against a transaction-level reference model.
module tb_ram_wb_arb;

   localparam int                ADDR_W  = 8;
   localparam int                DATA_W  = 16;
   localparam int                CNT_W   = 16;
   localparam logic [ADDR_W-1:0] IO_ADDR = 8'h40;
   localparam int                OUT_W   = 5 + ADDR_W + DATA_W + CNT_W;

   logic              clk = 1'b0;
   logic              RESET_N = 1'b0;
   logic              HOLD = 1'b0;
   logic              REQ_A = 1'b0, REQ_B = 1'b0;
   logic [ADDR_W-1:0] ADDR_A = '0, ADDR_B = '0;
   logic [DATA_W-1:0] DATA_A = '0, DATA_B = '0;
   logic              ACK_A, ACK_B, RAM_WEN, BUSY, IO_WR;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic [DATA_W-1:0] RAM_IN;
   logic [CNT_W-1:0]  WR_CNT;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one write transaction occupies the cycle after its grant.
   logic              m_wen, m_ack_a, m_ack_b, m_io;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic [CNT_W-1:0]  m_cnt;
   int                m_last_port;   // 0 = A, 1 = B

   ram_wb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IO_ADDR(IO_ADDR), .CNT_W(CNT_W)) dut (
      .CLK_WB(clk), .RESET_N(RESET_N), .HOLD(HOLD),
      .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A), .ACK_A(ACK_A),
      .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B), .ACK_B(ACK_B),
      .RAM_ADDR(RAM_ADDR), .RAM_IN(RAM_IN), .RAM_WEN(RAM_WEN),
      .BUSY(BUSY), .IO_WR(IO_WR), .WR_CNT(WR_CNT)
   );

   always #5 clk = ~clk;

   function automatic logic [OUT_W-1:0] outs();
      return {RAM_WEN, ACK_A, ACK_B, BUSY, IO_WR, RAM_ADDR, RAM_IN, WR_CNT};
   endfunction

   function automatic logic [OUT_W-1:0] expv();
      return {m_wen, m_ack_a, m_ack_b, m_wen, m_io, m_addr, m_data, m_cnt};
   endfunction

   task automatic model_reset();
      m_wen = 0; m_ack_a = 0; m_ack_b = 0; m_io = 0;
      m_addr = '0; m_data = '0; m_cnt = '0; m_last_port = 1;
   endtask

   task automatic model_step();
      int win;
      if (m_wen) begin
         m_wen = 0; m_ack_a = 0; m_ack_b = 0; m_io = 0;
         m_cnt = m_cnt + 1'b1;
      end else if (!HOLD && (REQ_A || REQ_B)) begin
         if (REQ_A && REQ_B) win = (m_last_port == 0) ? 1 : 0;
         else                win = REQ_B ? 1 : 0;
         m_last_port = win;
         m_addr  = (win == 1) ? ADDR_B : ADDR_A;
         m_data  = (win == 1) ? DATA_B : DATA_A;
         m_wen   = 1;
         m_ack_a = (win == 0);
         m_ack_b = (win == 1);
         m_io    = (m_addr == IO_ADDR);
      end
   endtask

   // Inputs are final at the call; outputs are sampled at the following negedge.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      RESET_N = 0; REQ_A = 0; REQ_B = 0; HOLD = 0;
      model_reset();
      @(posedge clk); @(negedge clk);
      RESET_N = 1;
   endtask

   task automatic test_reset();
      RESET_N = 0; REQ_A = 1; ADDR_A = 8'h05; DATA_A = 16'h1234; HOLD = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (outs() !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", outs());
      end
      RESET_N = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ACK_A) REQ_A = 0;
         n_checks++;
         if (outs() !== expv()) begin
            n_fail++; $display("FAIL reset_release c%0d: got %h want %h", i, outs(), expv());
         end
      end
      n_checks++;
      if (WR_CNT !== 16'd1) begin
         n_fail++; $display("FAIL reset_wrcnt: got %0d want 1", WR_CNT);
      end
   endtask

   task automatic test_single_a();
      REQ_A = 1; ADDR_A = 8'h01; DATA_A = 16'hbeaf;
      tick();
      n_checks++;
      if (!(RAM_WEN === 1'b1 && ACK_A === 1'b1 && ACK_B === 1'b0 && RAM_ADDR === 8'h01 && RAM_IN === 16'hbeaf)) begin
         n_fail++; $display("FAIL single_a_grant: got wen=%b ack_a=%b addr=%h data=%h want 1 1 01 beaf", RAM_WEN, ACK_A, RAM_ADDR, RAM_IN);
      end
      REQ_A = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (outs() !== expv()) begin
            n_fail++; $display("FAIL single_a c%0d: got %h want %h", i, outs(), expv());
         end
      end
   endtask

   task automatic test_contention();
      int k;
      do_reset();
      REQ_A = 1; ADDR_A = 8'h02; DATA_A = 16'h1111;
      REQ_B = 1; ADDR_B = 8'h03; DATA_B = 16'h2222;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_checks++;
         if (outs() !== expv()) begin
            n_fail++; $display("FAIL contention c%0d: got %h want %h", i, outs(), expv());
         end
         n_checks++;
         if (RAM_WEN !== ((i % 2) == 0)) begin
            n_fail++; $display("FAIL contention_rate c%0d: wen got %b want %b", i, RAM_WEN, (i % 2) == 0);
         end
         if (RAM_WEN) begin
            n_checks++;
            if (ACK_A !== ((k % 2) == 0) || ACK_B !== ((k % 2) == 1)) begin
               n_fail++; $display("FAIL contention_order w%0d: got a=%b b=%b want a=%b", k, ACK_A, ACK_B, (k % 2) == 0);
            end
            k++;
         end
      end
      n_checks++;
      if (WR_CNT !== 16'd8) begin
         n_fail++; $display("FAIL contention_wrcnt: got %0d want 8", WR_CNT);
      end
      REQ_A = 0; REQ_B = 0;
   endtask

   task automatic test_io_write();
      REQ_B = 1; ADDR_B = 8'h40; DATA_B = 16'hcafe;
      tick();
      n_checks++;
      if (!(IO_WR === 1'b1 && RAM_WEN === 1'b1 && ACK_B === 1'b1 && RAM_IN === 16'hcafe)) begin
         n_fail++; $display("FAIL io_write: got io=%b wen=%b ack_b=%b data=%h want 1 1 1 cafe", IO_WR, RAM_WEN, ACK_B, RAM_IN);
      end
      REQ_B = 0;
      tick();
      n_checks++;
      if (IO_WR !== 1'b0 || outs() !== expv()) begin
         n_fail++; $display("FAIL io_write_end: got %h want %h", outs(), expv());
      end
      REQ_A = 1; ADDR_A = 8'h07; DATA_A = 16'h0707;
      tick();
      n_checks++;
      if (IO_WR !== 1'b0 || RAM_WEN !== 1'b1 || outs() !== expv()) begin
         n_fail++; $display("FAIL io_nonio: got %h want %h", outs(), expv());
      end
      REQ_A = 0;
      tick();
   endtask

   task automatic test_hold();
      HOLD = 1; REQ_A = 1; ADDR_A = 8'h09; DATA_A = 16'h0909;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (RAM_WEN !== 1'b0 || ACK_A !== 1'b0 || outs() !== expv()) begin
            n_fail++; $display("FAIL hold_idle c%0d: got %h want %h", i, outs(), expv());
         end
      end
      HOLD = 0;
      tick();
      n_checks++;
      if (ACK_A !== 1'b1 || RAM_WEN !== 1'b1) begin
         n_fail++; $display("FAIL hold_release: got ack_a=%b wen=%b want 1 1", ACK_A, RAM_WEN);
      end
      HOLD = 1; REQ_A = 0;
      tick();
      n_checks++;
      if (BUSY !== 1'b0 || outs() !== expv()) begin
         n_fail++; $display("FAIL hold_in_write: got %h want %h", outs(), expv());
      end
      REQ_A = 1; ADDR_A = 8'h0a;
      tick();
      HOLD = 0;
      tick();
      n_checks++;
      if (ACK_A !== 1'b1 || outs() !== expv()) begin
         n_fail++; $display("FAIL hold_drop: got %h want %h", outs(), expv());
      end
      REQ_A = 0;
      tick();
   endtask

   task automatic test_reset_mid_write();
      int acks;
      REQ_A = 1; ADDR_A = 8'h11; DATA_A = 16'h5a5a;
      tick();
      n_checks++;
      if (RAM_WEN !== 1'b1) begin
         n_fail++; $display("FAIL midreset_setup: wen got %b want 1", RAM_WEN);
      end
      #1 RESET_N = 0;
      #1;
      model_reset();
      n_checks++;
      if (outs() !== '0) begin
         n_fail++; $display("FAIL midreset_async: got %h want 0", outs());
      end
      @(posedge clk); @(negedge clk);
      RESET_N = 1;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ACK_A) begin acks++; REQ_A = 0; end
         n_checks++;
         if (outs() !== expv()) begin
            n_fail++; $display("FAIL midreset_retry c%0d: got %h want %h", i, outs(), expv());
         end
      end
      n_checks++;
      if (acks != 1 || WR_CNT !== 16'd1) begin
         n_fail++; $display("FAIL midreset_once: got acks=%0d cnt=%0d want 1 1", acks, WR_CNT);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (REQ_A && ACK_A) REQ_A = 0;
         else if (REQ_A && $urandom_range(0, 15) == 0) REQ_A = 0;
         else if (!REQ_A && $urandom_range(0, 2) == 0) begin
            REQ_A = 1;
            ADDR_A = ($urandom_range(0, 3) == 0) ? IO_ADDR : ADDR_W'($urandom_range(0, 255));
            DATA_A = DATA_W'($urandom);
         end
         if (REQ_B && ACK_B) REQ_B = 0;
         else if (!REQ_B && $urandom_range(0, 2) == 0) begin
            REQ_B = 1;
            ADDR_B = ($urandom_range(0, 3) == 0) ? IO_ADDR : ADDR_W'($urandom_range(0, 255));
            DATA_B = DATA_W'($urandom);
         end
         HOLD = ($urandom_range(0, 3) == 0);
         tick();
         n_checks++;
         if (outs() !== expv()) begin
            n_fail++; $display("FAIL random c%0d: got %h want %h", i, outs(), expv());
         end
      end
      REQ_A = 0; REQ_B = 0; HOLD = 0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_a();
      test_contention();
      test_io_write();
      test_hold();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
